// File: rtl/counter_seq_pkg.sv
// ============================================================================
//  counter_seq_pkg
//  Shared state encodings and default widths for the counter sequencer.
//  Rev 1.0
// ============================================================================
`default_nettype none

package counter_seq_pkg;

  localparam int DEF_BITS = 4;
  localparam int DEF_REPW = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_UP   = S_UP,
    ST_DOWN = S_DOWN,
    ST_DONE = S_DONE
  } state_e;

endpackage

`default_nettype wire

// File: rtl/counter.sv
// ============================================================================
//  counter
//  Up/down counter: +1 when select=1, -1 when select=0, async clear.
//  Rev 1.0
// ============================================================================
`default_nettype none

module counter #(
  parameter int bits = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            select,
  output logic [bits-1:0] count
);

  logic [bits-1:0] count_q;
  logic [bits-1:0] count_d;

  always_comb begin
    count_d = select ? count_q + bits'(1) : count_q - bits'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/counter_seq_top.sv
// ============================================================================
//  counter_seq_top
//  Pin-level wrapper pairing the sequencer with its counter.
//  Rev 1.0
// ============================================================================
`default_nettype none

module counter_seq_top
  import counter_seq_pkg::*;
#(
  parameter int bits = DEF_BITS,
  parameter int repw = DEF_REPW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [bits-1:0] target,
  input  logic [repw-1:0] reps,
  output logic [bits-1:0] count,
  output logic            busy,
  output logic            done,
  output logic            err
);

  logic w_select;
  logic w_cnt_rst;

  counter_seq #(
    .bits (bits),
    .repw (repw)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .target     (target),
    .reps       (reps),
    .cnt_count  (count),
    .cnt_select (w_select),
    .cnt_rst    (w_cnt_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  counter #(
    .bits (bits)
  ) u_cnt (
    .clk    (clk),
    .rst    (w_cnt_rst | rst),
    .select (w_select),
    .count  (count)
  );

endmodule

`default_nettype wire

// File: rtl/counter_seq.sv
// ============================================================================
//  counter_seq
//  Drives a counter's select/rst so its count traces 0 -> target -> 0
//  for a programmed number of repetitions. All outputs come from flops.
//  Rev 1.0
// ============================================================================
`default_nettype none

module counter_seq
  import counter_seq_pkg::*;
#(
  parameter int bits = DEF_BITS,
  parameter int repw = DEF_REPW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic [bits-1:0] target,
  input  logic [repw-1:0] reps,
  input  logic [bits-1:0] cnt_count,
  output logic            cnt_select,
  output logic            cnt_rst,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_e          state_q, state_d;
  logic [bits-1:0] tgt_q, tgt_d;
  logic [repw-1:0] reps_q, reps_d;
  logic [repw-1:0] rep_q, rep_d;
  logic            sel_q, sel_d;
  logic            cnt_rst_q, cnt_rst_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    reps_d  = reps_q;
    rep_d   = rep_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // stop beats start, and suppresses the zero-target error too
        if (start && !stop) begin
          if (target != '0) begin
            tgt_d   = target;
            reps_d  = reps;
            rep_d   = reps;
            state_d = ST_UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_UP: begin
        if (stop) begin
          state_d = ST_DONE;
        end else if (cnt_count == tgt_q - bits'(1)) begin
          state_d = ST_DOWN;
        end
      end
      ST_DOWN: begin
        if (stop) begin
          state_d = ST_DONE;
        end else if (cnt_count == bits'(1)) begin
          if ((reps_q != '0) && (rep_q == repw'(1))) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_UP;
            if (reps_q != '0) begin
              rep_d = rep_q - repw'(1);
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they land in flops
    // together with it; select changes one edge before the turnaround.
    sel_d     = (state_d != ST_DOWN);
    cnt_rst_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    busy_d    = (state_d == ST_UP) || (state_d == ST_DOWN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tgt_q     <= '0;
      reps_q    <= '0;
      rep_q     <= '0;
      sel_q     <= 1'b1;
      cnt_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      reps_q    <= reps_d;
      rep_q     <= rep_d;
      sel_q     <= sel_d;
      cnt_rst_q <= cnt_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cnt_select = sel_q;
  assign cnt_rst    = cnt_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_seq.sv
// ============================================================================
//  tb_counter_seq
//  Self-checking bench for counter_seq driving a counter instance.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_counter_seq;
  import counter_seq_pkg::*;

  localparam int BITS = 4;
  localparam int REPW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [BITS-1:0] target = '0;
  logic [REPW-1:0] reps = '0;
  logic [BITS-1:0] cnt_count;
  logic            cnt_select;
  logic            cnt_rst;
  logic            busy;
  logic            done;
  logic            err;

  int checks = 0;
  int errors = 0;

  counter_seq #(.bits(BITS), .repw(REPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .target     (target),
    .reps       (reps),
    .cnt_count  (cnt_count),
    .cnt_select (cnt_select),
    .cnt_rst    (cnt_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  counter #(.bits(BITS)) u_cnt (
    .clk    (clk),
    .rst    (cnt_rst | rst),
    .select (cnt_select),
    .count  (cnt_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Triangle wave value k edges after the accepting edge, peak t
  function automatic int tri_val(int k, int t);
    int m;
    m = k % (2 * t);
    return (m <= t) ? m : 2 * t - m;
  endfunction

  // Start a finite sequence and check every cycle against the triangle model.
  // With disturb set, a stray start pulse and new target/reps arrive mid-run.
  task automatic run_seq(int t, int r, bit disturb);
    int n;
    int kd;
    n  = 2 * t * r;
    kd = disturb ? int'($urandom_range(1, n - 2)) : -1;
    target = BITS'(t);
    reps   = REPW'(r);
    stop   = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= n; k++) begin
      checks++;
      if (cnt_count !== BITS'(tri_val(k, t))) begin
        errors++;
        $display("FAIL seq_count t=%0d r=%0d k=%0d: got %0d expected %0d", t, r, k, cnt_count, tri_val(k, t));
      end
      checks++;
      if (busy !== (k < n)) begin
        errors++;
        $display("FAIL seq_busy t=%0d r=%0d k=%0d: got %0b expected %0b", t, r, k, busy, (k < n));
      end
      checks++;
      if (done !== (k == n)) begin
        errors++;
        $display("FAIL seq_done t=%0d r=%0d k=%0d: got %0b expected %0b", t, r, k, done, (k == n));
      end
      start = disturb && (k == kd);
      if (disturb && k >= kd) begin
        target = BITS'($urandom);
        reps   = REPW'($urandom);
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cnt_count !== '0 || cnt_rst !== 1'b1) begin
      errors++;
      $display("FAIL seq_idle t=%0d r=%0d: got busy=%0b done=%0b count=%0d cnt_rst=%0b expected 0 0 0 1",
               t, r, busy, done, cnt_count, cnt_rst);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cnt_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cnt_count !== '0) begin
        errors++;
        $display("FAIL reset_vals: got cnt_rst=%0b busy=%0b done=%0b err=%0b count=%0d expected 1 0 0 0 0",
                 cnt_rst, busy, done, err, cnt_count);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || cnt_count !== '0 || cnt_rst !== 1'b1 || cnt_select !== 1'b1) begin
        errors++;
        $display("FAIL idle_hold: got busy=%0b count=%0d cnt_rst=%0b sel=%0b expected 0 0 1 1",
                 busy, cnt_count, cnt_rst, cnt_select);
      end
    end
  endtask

  task automatic test_triangle();
    run_seq(3, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_seq(2, 1, 1'b0);
    run_seq(5, 2, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      int t;
      int r;
      t = int'($urandom_range(1, 15));
      r = int'($urandom_range(1, 3));
      run_seq(t, r, t >= 2);
    end
  endtask

  task automatic test_max_target();
    run_seq(15, 1, 1'b1);
  endtask

  task automatic test_infinite_stop();
    int ks;
    ks = 2 * int'($urandom_range(2, 6)) + 1;
    target = BITS'(1);
    reps   = '0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= ks; k++) begin
      checks++;
      if (cnt_count !== BITS'(k % 2) || busy !== 1'b1) begin
        errors++;
        $display("FAIL inf_toggle k=%0d: got count=%0d busy=%0b expected %0d 1", k, cnt_count, busy, k % 2);
      end
      stop = (k == ks);
      tick();
    end
    stop = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cnt_count !== '0) begin
      errors++;
      $display("FAIL stop_done: got done=%0b busy=%0b count=%0d expected 1 0 0", done, busy, cnt_count);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cnt_count !== '0 || cnt_rst !== 1'b1) begin
      errors++;
      $display("FAIL stop_idle: got done=%0b busy=%0b count=%0d cnt_rst=%0b expected 0 0 0 1",
               done, busy, cnt_count, cnt_rst);
    end
  endtask

  task automatic test_err();
    target = '0;
    reps   = REPW'(3);
    start  = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cnt_count !== '0) begin
      errors++;
      $display("FAIL err_pulse: got err=%0b busy=%0b count=%0d expected 1 0 0", err, busy, cnt_count);
    end
    tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got err=%0b busy=%0b expected 0 0", err, busy);
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_stop_wins: got err=%0b busy=%0b expected 0 0", err, busy);
    end
    target = BITS'(5);
    tick();
    checks++;
    if (busy !== 1'b0 || cnt_count !== '0) begin
      errors++;
      $display("FAIL start_stop_idle: got busy=%0b count=%0d expected 0 0", busy, cnt_count);
    end
    start = 1'b0;
    stop  = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    target = BITS'(8);
    reps   = REPW'(1);
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 11; k++) tick();
    checks++;
    if (cnt_count !== BITS'(5) || cnt_select !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_down: got count=%0d sel=%0b expected 5 0", cnt_count, cnt_select);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cnt_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        cnt_count !== '0 || cnt_select !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got cnt_rst=%0b busy=%0b done=%0b err=%0b count=%0d sel=%0b expected 1 0 0 0 0 1",
               cnt_rst, busy, done, err, cnt_count, cnt_select);
    end
    tick();
    rst = 1'b0;
    run_seq(2, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_back_to_back();
    test_infinite_stop();
    test_err();
    test_max_target();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
